// File: rtl/core_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_pkg : funct3 codes, LSU state type, store/load lane helpers      |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
package core_pkg;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } lsu_state_e;

   function automatic logic [3:0] lane_enable(input logic [2:0] funct3,
                                              input logic [1:0] offset);
      logic [3:0] be;
      case (funct3)
         F3_B:    be = 4'b0001 << offset;
         F3_H:    be = offset[1] ? 4'b1100 : 4'b0011;
         F3_W:    be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   // Sub-word store data is replicated so any enabled lane sees the right byte.
   function automatic logic [31:0] store_align(input logic [2:0]  funct3,
                                               input logic [31:0] wdata);
      logic [31:0] d;
      case (funct3)
         F3_B:    d = {4{wdata[7:0]}};
         F3_H:    d = {2{wdata[15:0]}};
         default: d = wdata;
      endcase
      return d;
   endfunction

   function automatic logic [31:0] load_extract(input logic [2:0]  funct3,
                                                input logic [1:0]  offset,
                                                input logic [31:0] data);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = 8'(data >> {offset, 3'b000});
      h = offset[1] ? data[31:16] : data[15:0];
      case (funct3)
         F3_B:    r = {{24{b[7]}}, b};
         F3_BU:   r = {24'h0, b};
         F3_H:    r = {{16{h[15]}}, h};
         F3_HU:   r = {16'h0, h};
         F3_W:    r = data;
         default: r = 32'h0;
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_bank : 32-bit single-port RAM, byte write enables, registered rd |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
module dmem_bank #(
   parameter int ADDRW     = 10,
   parameter bit INIT_ZERO = 1'b1
) (
   input  logic             clk,
   input  logic             en_i,
   input  logic [3:0]       be_i,
   input  logic [ADDRW-1:0] addr_i,
   input  logic [31:0]      wdata_i,
   output logic [31:0]      rdata_o
);

   localparam int DEPTH = 2**ADDRW;

   // The array carries no reset so it maps onto block RAM; zero fill is load-time only.
   generate
      if (INIT_ZERO) begin : g_init_zero
         logic [31:0] mem_q [DEPTH] = '{default: 32'h0};

         always_ff @(posedge clk) begin
            if (en_i) begin
               for (int b = 0; b < 4; b++) begin
                  if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
               end
               rdata_o <= mem_q[addr_i];
            end
         end
      end else begin : g_no_init
         logic [31:0] mem_q [DEPTH];

         always_ff @(posedge clk) begin
            if (en_i) begin
               for (int b = 0; b < 4; b++) begin
                  if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
               end
               rdata_o <= mem_q[addr_i];
            end
         end
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/data_mem_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_mem_lsu : RV32I load/store unit with byte-addressable data RAM   |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
module data_mem_lsu
   import core_pkg::*;
#(
   parameter int ADDRW     = 10,
   parameter bit INIT_ZERO = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   lsu_state_e       state_q;
   logic             we_q;
   logic             err_q;
   logic [2:0]       funct3_q;
   logic [1:0]       offset_q;
   logic [3:0]       be_q;
   logic [31:0]      wdata_q;
   logic [ADDRW-1:0] index_q;
   logic             resp_valid_q;
   logic [31:0]      rdata_hold_q;
   logic             err_hold_q;

   logic             fire;
   logic             funct3_bad;
   logic             misaligned;
   logic             addr_oob;
   logic             err_d;
   logic             bank_en;
   logic [31:0]      bank_rdata;
   logic [31:0]      rdata_fmt;

   assign req_ready = rst_n && (state_q != ST_ACCESS);
   assign fire      = req_valid && req_ready;

   assign addr_oob = |req_addr[31:ADDRW+2];

   always_comb begin
      funct3_bad = 1'b0;
      misaligned = 1'b0;
      if (req_we) begin
         funct3_bad = (req_funct3 != F3_B) && (req_funct3 != F3_H) && (req_funct3 != F3_W);
      end else begin
         funct3_bad = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7);
      end
      case (req_funct3)
         F3_H, F3_HU: misaligned = req_addr[0];
         F3_W:        misaligned = |req_addr[1:0];
         default:     misaligned = 1'b0;
      endcase
   end

   assign err_d = funct3_bad | misaligned | addr_oob;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         we_q         <= 1'b0;
         err_q        <= 1'b0;
         funct3_q     <= 3'd0;
         offset_q     <= 2'd0;
         be_q         <= 4'd0;
         wdata_q      <= 32'h0;
         index_q      <= '0;
         resp_valid_q <= 1'b0;
         rdata_hold_q <= 32'h0;
         err_hold_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_RESP: begin
               // Freeze the outgoing response so the outputs hold after the pulse.
               if (state_q == ST_RESP) begin
                  rdata_hold_q <= rdata_fmt;
                  err_hold_q   <= err_q;
               end
               resp_valid_q <= 1'b0;
               if (fire) begin
                  state_q  <= ST_ACCESS;
                  we_q     <= req_we;
                  err_q    <= err_d;
                  funct3_q <= req_funct3;
                  offset_q <= req_addr[1:0];
                  be_q     <= req_we ? lane_enable(req_funct3, req_addr[1:0]) : 4'b0000;
                  wdata_q  <= store_align(req_funct3, req_wdata);
                  index_q  <= req_addr[ADDRW+1:2];
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_ACCESS: begin
               state_q      <= ST_RESP;
               resp_valid_q <= 1'b1;
            end
            default: begin
               state_q      <= ST_IDLE;
               resp_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Asynchronous reset drops state_q out of ACCESS, so an interrupted store never writes.
   assign bank_en = (state_q == ST_ACCESS) && !err_q;

   dmem_bank #(
      .ADDRW     (ADDRW),
      .INIT_ZERO (INIT_ZERO)
   ) u_bank (
      .clk     (clk),
      .en_i    (bank_en),
      .be_i    (be_q),
      .addr_i  (index_q),
      .wdata_i (wdata_q),
      .rdata_o (bank_rdata)
   );

   assign rdata_fmt  = (we_q || err_q) ? 32'h0 : load_extract(funct3_q, offset_q, bank_rdata);

   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_valid_q ? rdata_fmt : rdata_hold_q;
   assign resp_err   = resp_valid_q ? err_q     : err_hold_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_data_mem_lsu : vector table, corner sequences and random vs model  |
// | Revision        : 1.0                                                 |
// +----------------------------------------------------------------------+
module tb_data_mem_lsu;

   localparam int AW    = 6;
   localparam int NBYTE = 4 * (2**AW);

   localparam logic [2:0] OP_B  = 3'd0;
   localparam logic [2:0] OP_H  = 3'd1;
   localparam logic [2:0] OP_W  = 3'd2;
   localparam logic [2:0] OP_BU = 3'd4;
   localparam logic [2:0] OP_HU = 3'd5;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   int n_pass  = 0;
   int n_total = 0;

   logic [7:0] mref [NBYTE];

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];

   data_mem_lsu #(
      .ADDRW     (AW),
      .INIT_ZERO (1'b1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // Reference: a flat byte array, addressed and sized straight from the RV32I rules.
   task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd, output logic e);
      int          size;
      bit          legal;
      logic [31:0] v;
      legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      size  = 1 << f3[1:0];
      e     = !legal || ((addr % size) != 0) || (addr >= NBYTE);
      rd    = 32'h0;
      if (!e) begin
         if (we) begin
            for (int i = 0; i < size; i++) mref[addr + i] = wdata[8*i +: 8];
         end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v = v | (32'(mref[addr + i]) << (8*i));
            if (!f3[2] && size == 1 && v[7])  v = v | 32'hFFFF_FF00;
            if (!f3[2] && size == 2 && v[15]) v = v | 32'hFFFF_0000;
            rd = v;
         end
      end
   endtask

   task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er);
      int n;
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      n = 0;
      while (!req_ready && n < 8) begin
         @(posedge clk); #1; n++;
      end
      @(posedge clk); #1;
      req_valid  = 1'b0;
      req_we     = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      n = 0;
      while (!resp_valid && n < 6) begin
         @(posedge clk); #1; n++;
      end
      chk({tag, " latency"}, n, 1);
      rd = resp_rdata;
      er = resp_err;
      @(posedge clk); #1;
      chk({tag, " pulse end"}, {31'h0, resp_valid}, 32'h0);
      chk({tag, " rdata hold"}, resp_rdata, rd);
   endtask

   logic [31:0] rd, mrd;
   logic        er, mer;

   logic        bb_we  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
   logic [2:0]  bb_f3  [4] = '{OP_W, OP_W, OP_BU, OP_H};
   logic [31:0] bb_addr[4] = '{32'h30, 32'h30, 32'h33, 32'h30};
   logic [31:0] bb_wd  [4] = '{32'hCAFE_BABE, 32'h0, 32'h0, 32'h0};
   logic [31:0] bb_exp [4] = '{32'h0, 32'hCAFE_BABE, 32'h0000_00CA, 32'hFFFF_BABE};

   initial begin
      int k, nresp, last_acc, bad_gap, bad_ready, seen;
      logic rdy, vld, acc;

      for (int i = 0; i < NBYTE; i++) mref[i] = 8'h0;
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
      req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset ready", {31'h0, req_ready}, 32'h0);
      chk("reset resp_valid", {31'h0, resp_valid}, 32'h0);
      chk("reset rdata", resp_rdata, 32'h0);
      chk("reset err", {31'h0, resp_err}, 32'h0);
      rst_n = 1'b1;
      #1;
      chk("ready after release", {31'h0, req_ready}, 32'h1);

      vecs.push_back('{1'b1, OP_W,  32'h10, 32'hDEAD_BEEF, 32'h0,         1'b0});
      vecs.push_back('{1'b0, OP_W,  32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0});
      vecs.push_back('{1'b1, OP_B,  32'h11, 32'h0000_0080, 32'h0,         1'b0});
      vecs.push_back('{1'b0, OP_B,  32'h11, 32'h0,         32'hFFFF_FF80, 1'b0});
      vecs.push_back('{1'b0, OP_BU, 32'h11, 32'h0,         32'h0000_0080, 1'b0});
      vecs.push_back('{1'b0, OP_W,  32'h10, 32'h0,         32'hDEAD_80EF, 1'b0});
      vecs.push_back('{1'b1, OP_H,  32'h12, 32'h0000_1234, 32'h0,         1'b0});
      vecs.push_back('{1'b0, OP_H,  32'h12, 32'h0,         32'h0000_1234, 1'b0});
      vecs.push_back('{1'b1, OP_H,  32'h12, 32'h0000_F00D, 32'h0,         1'b0});
      vecs.push_back('{1'b0, OP_HU, 32'h12, 32'h0,         32'h0000_F00D, 1'b0});
      vecs.push_back('{1'b0, OP_H,  32'h12, 32'h0,         32'hFFFF_F00D, 1'b0});
      vecs.push_back('{1'b0, OP_W,  32'h12, 32'h0,         32'h0,         1'b1});
      vecs.push_back('{1'b1, OP_H,  32'h13, 32'h0000_AAAA, 32'h0,         1'b1});
      vecs.push_back('{1'b1, OP_W,  32'h100, 32'h1111_1111, 32'h0,        1'b1});
      vecs.push_back('{1'b1, 3'd3,  32'h10, 32'h2222_2222, 32'h0,         1'b1});
      vecs.push_back('{1'b0, 3'd3,  32'h10, 32'h0,         32'h0,         1'b1});
      vecs.push_back('{1'b1, 3'd7,  32'h10, 32'h3333_3333, 32'h0,         1'b1});
      vecs.push_back('{1'b0, 3'd6,  32'h10, 32'h0,         32'h0,         1'b1});
      vecs.push_back('{1'b0, OP_HU, 32'h11, 32'h0,         32'h0,         1'b1});
      vecs.push_back('{1'b0, OP_W,  32'h8000_0010, 32'h0,  32'h0,         1'b1});
      vecs.push_back('{1'b0, OP_W,  32'h10, 32'h0,         32'hF00D_80EF, 1'b0});
      vecs.push_back('{1'b1, OP_B,  32'h14, 32'hFFFF_FF7F, 32'h0,         1'b0});
      vecs.push_back('{1'b0, OP_B,  32'h14, 32'h0,         32'h0000_007F, 1'b0});
      vecs.push_back('{1'b0, OP_W,  32'h14, 32'h0,         32'h0000_007F, 1'b0});
      vecs.push_back('{1'b0, OP_B,  32'hFF, 32'h0,         32'h0,         1'b0});
      vecs.push_back('{1'b1, OP_B,  32'h103, 32'h0000_0055, 32'h0,        1'b1});

      foreach (vecs[i]) begin
         model(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, mrd, mer);
         do_req($sformatf("vec%0d", i), vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er);
         chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
         chk($sformatf("vec%0d err", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
      end

      // Back-to-back: valid held high, acceptance every second cycle.
      k = 0; nresp = 0; last_acc = -1; bad_gap = 0; bad_ready = 0;
      req_valid = 1'b1; req_we = bb_we[0]; req_funct3 = bb_f3[0];
      req_addr = bb_addr[0]; req_wdata = bb_wd[0];
      for (int cyc = 0; cyc < 20; cyc++) begin
         rdy = req_ready; vld = req_valid;
         @(posedge clk); #1;
         acc = vld && rdy;
         if (acc) begin
            if (last_acc >= 0 && cyc - last_acc != 2) bad_gap++;
            last_acc = cyc;
            model(bb_we[k], bb_f3[k], bb_addr[k], bb_wd[k], mrd, mer);
            k++;
         end
         if (req_ready !== !acc) bad_ready++;
         if (resp_valid) begin
            if (nresp < 4) begin
               chk($sformatf("b2b resp%0d rdata", nresp), resp_rdata, bb_exp[nresp]);
               chk($sformatf("b2b resp%0d err", nresp), {31'h0, resp_err}, 32'h0);
            end
            nresp++;
         end
         if (k < 4) begin
            req_we = bb_we[k]; req_funct3 = bb_f3[k];
            req_addr = bb_addr[k]; req_wdata = bb_wd[k];
         end else begin
            req_valid = 1'b0;
         end
      end
      chk("b2b accepts", k, 4);
      chk("b2b responses", nresp, 4);
      chk("b2b accept spacing", bad_gap, 0);
      chk("b2b ready pattern", bad_ready, 0);

      // Reset while a store is in ACCESS.
      model(1'b0, OP_W, 32'h10, 32'h0, mrd, mer);
      do_req("pre-rst load", 1'b0, OP_W, 32'h10, 32'h0, rd, er);
      chk("pre-rst load rdata", rd, mrd);
      model(1'b1, OP_W, 32'h20, 32'h0, mrd, mer);
      do_req("clear 0x20", 1'b1, OP_W, 32'h20, 32'h0, rd, er);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = OP_W;
      req_addr = 32'h20; req_wdata = 32'h5555_5555;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("rst: in ACCESS", {31'h0, req_ready}, 32'h0);
      rst_n = 1'b0;
      #1;
      chk("rst: ready", {31'h0, req_ready}, 32'h0);
      chk("rst: resp_valid", {31'h0, resp_valid}, 32'h0);
      chk("rst: rdata", resp_rdata, 32'h0);
      chk("rst: err", {31'h0, resp_err}, 32'h0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (resp_valid) seen++;
      end
      chk("rst: no response", seen, 0);
      chk("rst: ready after", {31'h0, req_ready}, 32'h1);
      model(1'b0, OP_W, 32'h20, 32'h0, mrd, mer);
      do_req("post-rst load", 1'b0, OP_W, 32'h20, 32'h0, rd, er);
      chk("post-rst load rdata", rd, 32'h0);
      chk("post-rst load err", {31'h0, er}, 32'h0);

      // Random traffic against the byte-array model.
      for (int i = 0; i < 300; i++) begin
         logic        we;
         logic [2:0]  f3;
         logic [31:0] addr, wd;
         we = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 9) == 0) addr = $urandom;
         else if ($urandom_range(0, 4) == 0) addr = $urandom_range(0, NBYTE + 7);
         else addr = $urandom_range(0, 47);
         if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
         wd = $urandom;
         model(we, f3, addr, wd, mrd, mer);
         do_req($sformatf("rnd%0d", i), we, f3, addr, wd, rd, er);
         chk($sformatf("rnd%0d rdata", i), rd, mrd);
         chk($sformatf("rnd%0d err", i), {31'h0, er}, {31'h0, mer});
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
